apb_master_ctrl: RTL
====================

// Module: apb_master_ctrl
// PURPOSE
// - APB initiator that drives the I2C core's APB register port (pclk domain) from a simple command/response interface.
// - Issues one SETUP + ACCESS transfer per accepted command.
// - Waits on pready and returns read data/status.
// - Rejects commands that violate the register map direction rules before they reach the bus.
// PARAMETERS
// - ADDR_W       8   width of paddr / cmd_addr
// - DATA_W       8   width of pwdata / prdata / cmd_wdata / rsp_rdata
// - TIMEOUT_CYC  16  ACCESS cycles without pready before abort (used only with APB_MASTER_TIMEOUT_EN)
// PORTS
// - pclk       in   1       clock; all logic on rising edge
// - preset     in   1       synchronous, active-high reset
// - cmd_valid  in   1       command request
// - cmd_ready  out  1       command accepted when cmd_valid && cmd_ready
// - cmd_write  in   1       1 = write, 0 = read
// - cmd_addr   in   ADDR_W  register address
// - cmd_wdata  in   DATA_W  write data
// - rsp_valid  out  1       one-cycle response strobe
// - rsp_rdata  out  DATA_W  read data (0 for writes/errors)
// - rsp_err    out  1       direction violation, pslverr or timeout
// - pselx      out  1       APB select
// - penable    out  1       APB enable
// - pwrite     out  1       APB direction
// - paddr      out  ADDR_W  APB address
// - pwdata     out  DATA_W  APB write data
// - prdata     in   DATA_W  APB read data
// - pready     in   1       APB ready
// - pslverr    in   1       APB slave error
// BEHAVIOUR
// - Reset (preset=1 at edge): state=IDLE; pselx=penable=pwrite=0; paddr=pwdata=0; rsp_valid=rsp_err=0; rsp_rdata=0; cmd_ready=1 after reset release.
// - Reset mid-transfer aborts immediately; no response is issued for the aborted command.
// - Register map legality:
//   - writable: addr 1, 2, 4, 6
//   - read-only: addr 3, 5
//   - any other address, write to 3/5, or read of 1/2/4/6 = illegal
// - States: IDLE, SETUP, ACCESS, RESP.
//   - IDLE: cmd_ready=1.
//     - Accept of a legal command -> SETUP; capture pwrite/paddr/pwdata.
//     - Accept of an illegal command -> RESP with err=1; no bus activity.
//   - SETUP: pselx=1, penable=0; exactly one cycle -> ACCESS.
//   - ACCESS: pselx=1, penable=1; remain while pready=0.
//     - On pready=1 -> RESP; capture prdata (reads only) and pslverr into err.
//   - RESP: rsp_valid=1 for exactly one cycle; pselx=penable=0 -> IDLE.
// - cmd_ready=0 in SETUP/ACCESS/RESP; commands are never queued.
// - pwrite/paddr/pwdata stable from SETUP through the last ACCESS cycle; pwdata=0 for reads.
// - Zero-wait read: accept at cycle N, SETUP N+1, ACCESS N+2 (pready=1), rsp_valid N+3, next accept N+4.
// - Illegal command: accept N, rsp_valid N+1 with rsp_err=1.
// - rsp_rdata/rsp_err are valid only while rsp_valid=1; both are 0 otherwise.
// - cmd_* inputs are ignored while cmd_ready=0.
// CONFIGURATION
// - APB_MASTER_TIMEOUT_EN defined:
//   - Counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
//   - When the count reaches TIMEOUT_CYC -> RESP with rsp_err=1, rsp_rdata=0; pselx/penable drop in RESP.
//   - pready in the same cycle as the limit wins; the normal response is returned.
// - APB_MASTER_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for pready.
// TESTING
// - Write addr 2, data 8'hA5, pready=1 immediately
//   -> pselx N+1, penable N+2 with pwdata=A5, pwrite=1; rsp_valid N+3, rsp_err=0.
// - Read addr 3, pready low for 3 ACCESS cycles, prdata=8'h3C
//   -> penable held 4 cycles, paddr stable; rsp_rdata=3C, rsp_err=0.
// - Write addr 5, then read addr 4, then read addr 0
//   -> each: no pselx, rsp_valid next cycle with rsp_err=1.
// - Write addr 6 with pslverr=1 alongside pready -> rsp_err=1, rsp_rdata=0.
// - preset asserted during ACCESS -> all outputs 0 next edge, no rsp_valid, cmd_ready=1 after release.
// - Timeout enabled, pready held 0 -> rsp_err=1 after 16 ACCESS cycles.
//   - Same with pready=1 on the 16th cycle -> normal response.

Source files
------------

// File: rtl/apb_master_ctrl_if.sv
// Command/response and APB bus bundle for apb_master_ctrl.
// master: the APB initiator's view. slave: the peer's view (command source plus APB target).
interface apb_master_ctrl_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              pselx;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, pselx, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, pselx, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB initiator for the I2C core register port: one SETUP + ACCESS transfer per command,
// with register-map direction checks done before the bus is touched.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles
// without pready.
module apb_master_ctrl #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic              pclk,
   input  logic              preset,
   apb_master_ctrl_if.master bus
);
   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_t;

   state_t state;
   logic   cmd_legal;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] to_cnt;
`endif

   // Register map: 1/2/4/6 are write-only targets, 3/5 are read-only; all else is illegal.
   always_comb begin
      cmd_legal = 1'b0;
      if (bus.cmd_write) begin
         cmd_legal = (bus.cmd_addr == ADDR_W'(1)) || (bus.cmd_addr == ADDR_W'(2)) ||
                     (bus.cmd_addr == ADDR_W'(4)) || (bus.cmd_addr == ADDR_W'(6));
      end else begin
         cmd_legal = (bus.cmd_addr == ADDR_W'(3)) || (bus.cmd_addr == ADDR_W'(5));
      end
   end

   // Transfer FSM; every output is registered here.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state         <= StIdle;
         bus.cmd_ready <= 1'b1;
         bus.pselx     <= 1'b0;
         bus.penable   <= 1'b0;
         bus.pwrite    <= 1'b0;
         bus.paddr     <= '0;
         bus.pwdata    <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
         to_cnt        <= '0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (bus.cmd_valid) begin
                  bus.cmd_ready <= 1'b0;
                  if (cmd_legal) begin
                     state      <= StSetup;
                     bus.pselx  <= 1'b1;
                     bus.pwrite <= bus.cmd_write;
                     bus.paddr  <= bus.cmd_addr;
                     bus.pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
                  end else begin
                     // Rejected commands never reach the bus.
                     state         <= StResp;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= '0;
                  end
               end
            end
            StSetup: begin
               state       <= StAccess;
               bus.penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
               to_cnt      <= '0;
`endif
            end
            StAccess: begin
               // pready wins over a timeout landing in the same cycle.
               if (bus.pready) begin
                  state         <= StResp;
                  bus.pselx     <= 1'b0;
                  bus.penable   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= bus.pslverr;
                  bus.rsp_rdata <= (!bus.pwrite && !bus.pslverr) ? bus.prdata : '0;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  state         <= StResp;
                  bus.pselx     <= 1'b0;
                  bus.penable   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            StResp: begin
               state         <= StIdle;
               bus.cmd_ready <= 1'b1;
               bus.rsp_valid <= 1'b0;
               bus.rsp_err   <= 1'b0;
               bus.rsp_rdata <= '0;
            end
            default: state <= StIdle;
         endcase
      end
   end
endmodule
